multicycle_controller: RTL and testbench
========================================

Name: multicycle_controller

Overview:
- Multicycle successor to the single-cycle main decoder.
- Moore FSM that sequences each RV32I instruction over several cycles on a shared ALU and a unified instruction/data memory.
- Supports lw, sw, R-type, I-type ALU, beq and, optionally, jal.
- Optional memory wait-state handshake; flags unknown opcodes instead of leaving outputs undriven.

Parameters:
- MEM_WAIT, 0: 1 = honour mem_ready in memory states; 0 = mem_ready ignored and treated as 1.
- ENABLE_JAL, 1: 1 = decode jal (1101111); 0 = jal is treated as illegal.

Ports:
- clk  input  1  system clock; all state changes on the rising edge.
- reset  input  1  synchronous, active-high reset.
- opcode  input  7  instr[6:0] from the instruction register.
- zero  input  1  ALU zero flag.
- mem_ready  input  1  memory access completes this cycle.
- pc_write  output  1  PC register enable; equals pc_update OR (branch AND zero).
- adr_src  output  1  memory address select: 0 = PC, 1 = result.
- mem_write  output  1  memory write strobe.
- ir_write  output  1  instruction register and old-PC register enable.
- result_src  output  2  result mux: 00 = ALUOut, 01 = read data, 10 = ALU result.
- alu_src_a  output  2  ALU A mux: 00 = PC, 01 = old PC, 10 = rs1 data.
- alu_src_b  output  2  ALU B mux: 00 = rs2 data, 01 = immediate, 10 = constant 4.
- alu_op  output  2  to ALU decoder: 00 = add, 01 = sub, 10 = funct-decoded.
- imm_src  output  2  immediate type: 00 = I, 01 = S, 10 = B, 11 = J.
- reg_write  output  1  register file write enable.
- illegal_instr  output  1  one-cycle pulse on an unsupported opcode.
- state  output  4  current state, for debug and bench.

Behaviour:
- State encoding: FETCH=0, DECODE=1, MEMADR=2, MEMREAD=3, MEMWB=4, MEMWRITE=5, EXECUTER=6, EXECUTEI=7, ALUWB=8, BEQ=9, JAL=10. Codes 11-15 go to FETCH.
- Reset: state = FETCH on the next edge. While reset = 1, pc_write, ir_write, mem_write, reg_write and illegal_instr are forced to 0. All other outputs take their FETCH values.
- Outputs are a pure function of state, except:
  - imm_src: combinational from opcode in every state. lw and I-type = 00, sw = 01, beq = 10, jal = 11, else 00.
  - pc_write: uses the live zero input.
- Defaults in every state, unless listed below: all enables 0, all selects 00.
- FETCH: adr_src=0, alu_src_a=00, alu_src_b=10, alu_op=00, result_src=10. ir_write=1 and pc_update=1 only when mem_ready. Moves to DECODE on mem_ready, else holds.
- DECODE: alu_src_a=01, alu_src_b=01, alu_op=00 (branch target into ALUOut). Next state by opcode:
  - 0000011 or 0100011 -> MEMADR
  - 0110011 -> EXECUTER
  - 0010011 -> EXECUTEI
  - 1100011 -> BEQ
  - 1101111 -> JAL (if ENABLE_JAL)
  - anything else -> FETCH, with illegal_instr=1 this cycle only.
- MEMADR: alu_src_a=10, alu_src_b=01. Moves to MEMREAD if opcode=lw, else MEMWRITE.
- MEMREAD: adr_src=1, result_src=00. Moves to MEMWB on mem_ready, else holds.
- MEMWB: result_src=01, reg_write=1. Moves to FETCH.
- MEMWRITE: adr_src=1, result_src=00, mem_write=1 held every cycle until mem_ready. Moves to FETCH on mem_ready.
- EXECUTER: alu_src_a=10, alu_src_b=00, alu_op=10. Moves to ALUWB.
- EXECUTEI: alu_src_a=10, alu_src_b=01, alu_op=10. Moves to ALUWB.
- ALUWB: result_src=00, reg_write=1. Moves to FETCH.
- BEQ: alu_src_a=10, alu_src_b=00, alu_op=01, result_src=00, branch=1. Moves to FETCH.
- JAL: alu_src_a=01, alu_src_b=10, alu_op=00, result_src=00, pc_update=1. Moves to ALUWB (writes PC+4 to rd).
- Latency with MEM_WAIT=0 (FETCH to next FETCH): lw 5, sw 4, R/I 4, beq 3, jal 4 cycles. Each mem_ready=0 cycle in FETCH, MEMREAD or MEMWRITE adds one cycle.
- Reset mid-instruction: takes effect on the next edge regardless of state or mem_ready. No write strobe is asserted in the reset cycle.
- opcode is sampled only in DECODE and MEMADR. Changes in other states have no effect except on imm_src.

Test Plan:
- MEM_WAIT=0, lw: reset, release, opcode=0000011 -> states 0,1,2,3,4,0. reg_write=1 only in state 4 with result_src=01. ir_write=1 only in cycle 0.
- sw with MEM_WAIT=1 and mem_ready low for 2 cycles in MEMWRITE -> state 5 for 3 cycles, mem_write=1 all 3, then FETCH. Memory-stage imm_src=01 throughout.
- beq: zero=1 -> pc_write=1 in BEQ and 3-cycle instruction. Repeat with zero=0 -> pc_write=0 in BEQ.
- jal, ENABLE_JAL=1 -> states 0,1,10,8,0, pc_write=1 in JAL, imm_src=11. With ENABLE_JAL=0 -> illegal_instr pulse in DECODE, then FETCH.
- opcode=1111111 -> illegal_instr=1 exactly one cycle, no reg_write or mem_write, back to FETCH.
- Assert reset while in MEMWRITE with mem_ready=0 -> mem_write=0 during the reset cycle, state=0 on the next edge.

Source files
------------

// File: rtl/multicycle_controller_if.sv
// Control bundle between the multicycle controller and its datapath/memory.
// master = controller side, slave = datapath side.
interface multicycle_controller_if;
    logic [6:0] opcode;
    logic       zero;
    logic       mem_ready;
    logic       pc_write;
    logic       adr_src;
    logic       mem_write;
    logic       ir_write;
    logic [1:0] result_src;
    logic [1:0] alu_src_a;
    logic [1:0] alu_src_b;
    logic [1:0] alu_op;
    logic [1:0] imm_src;
    logic       reg_write;
    logic       illegal_instr;
    logic [3:0] state;

    modport master (
        input  opcode, zero, mem_ready,
        output pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
               alu_src_b, alu_op, imm_src, reg_write, illegal_instr, state
    );

    modport slave (
        output opcode, zero, mem_ready,
        input  pc_write, adr_src, mem_write, ir_write, result_src, alu_src_a,
               alu_src_b, alu_op, imm_src, reg_write, illegal_instr, state
    );
endinterface

// File: rtl/multicycle_controller.sv
// Moore FSM sequencing RV32I lw/sw/R/I/beq/jal over a shared ALU and unified memory.
// Outputs decode from state; imm_src decodes the live opcode, pc_write uses the live zero.
module multicycle_controller #(
    parameter int unsigned MEM_WAIT   = 0,
    parameter int unsigned ENABLE_JAL = 1
) (
    input  logic                           clk,
    input  logic                           reset,
    multicycle_controller_if.master        bus_io
);

    typedef enum logic [3:0] {
        StFetch    = 4'd0,
        StDecode   = 4'd1,
        StMemAdr   = 4'd2,
        StMemRead  = 4'd3,
        StMemWb    = 4'd4,
        StMemWrite = 4'd5,
        StExecuteR = 4'd6,
        StExecuteI = 4'd7,
        StAluWb    = 4'd8,
        StBeq      = 4'd9,
        StJal      = 4'd10
    } state_e;

    localparam logic [6:0] OpLw   = 7'b0000011;
    localparam logic [6:0] OpSw   = 7'b0100011;
    localparam logic [6:0] OpR    = 7'b0110011;
    localparam logic [6:0] OpI    = 7'b0010011;
    localparam logic [6:0] OpBeq  = 7'b1100011;
    localparam logic [6:0] OpJal  = 7'b1101111;

    state_e state_q, state_d;
    state_e dec_state;
    logic   ready;
    logic   pc_update, branch;
    logic   ir_write_c, mem_write_c, reg_write_c, illegal_c;

    assign ready = (MEM_WAIT != 0) ? bus_io.mem_ready : 1'b1;
    // During reset the outputs decode as FETCH regardless of the held state.
    assign dec_state = reset ? StFetch : state_q;

    always_ff @(posedge clk) begin
        if (reset) state_q <= StFetch;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d           = state_q;
        pc_update         = 1'b0;
        branch            = 1'b0;
        ir_write_c        = 1'b0;
        mem_write_c       = 1'b0;
        reg_write_c       = 1'b0;
        illegal_c         = 1'b0;
        bus_io.adr_src    = 1'b0;
        bus_io.result_src = 2'b00;
        bus_io.alu_src_a  = 2'b00;
        bus_io.alu_src_b  = 2'b00;
        bus_io.alu_op     = 2'b00;
        case (dec_state)
            StFetch: begin
                bus_io.alu_src_b  = 2'b10;
                bus_io.result_src = 2'b10;
                if (ready) begin
                    ir_write_c = 1'b1;
                    pc_update  = 1'b1;
                    state_d    = StDecode;
                end
            end
            StDecode: begin
                bus_io.alu_src_a = 2'b01;
                bus_io.alu_src_b = 2'b01;
                case (bus_io.opcode)
                    OpLw, OpSw: state_d = StMemAdr;
                    OpR:        state_d = StExecuteR;
                    OpI:        state_d = StExecuteI;
                    OpBeq:      state_d = StBeq;
                    OpJal: begin
                        if (ENABLE_JAL != 0) begin
                            state_d = StJal;
                        end else begin
                            illegal_c = 1'b1;
                            state_d   = StFetch;
                        end
                    end
                    default: begin
                        illegal_c = 1'b1;
                        state_d   = StFetch;
                    end
                endcase
            end
            StMemAdr: begin
                bus_io.alu_src_a = 2'b10;
                bus_io.alu_src_b = 2'b01;
                state_d = (bus_io.opcode == OpLw) ? StMemRead : StMemWrite;
            end
            StMemRead: begin
                bus_io.adr_src = 1'b1;
                if (ready) state_d = StMemWb;
            end
            StMemWb: begin
                bus_io.result_src = 2'b01;
                reg_write_c       = 1'b1;
                state_d           = StFetch;
            end
            StMemWrite: begin
                bus_io.adr_src = 1'b1;
                mem_write_c    = 1'b1;
                if (ready) state_d = StFetch;
            end
            StExecuteR: begin
                bus_io.alu_src_a = 2'b10;
                bus_io.alu_op    = 2'b10;
                state_d          = StAluWb;
            end
            StExecuteI: begin
                bus_io.alu_src_a = 2'b10;
                bus_io.alu_src_b = 2'b01;
                bus_io.alu_op    = 2'b10;
                state_d          = StAluWb;
            end
            StAluWb: begin
                reg_write_c = 1'b1;
                state_d     = StFetch;
            end
            StBeq: begin
                bus_io.alu_src_a = 2'b10;
                bus_io.alu_op    = 2'b01;
                branch           = 1'b1;
                state_d          = StFetch;
            end
            StJal: begin
                bus_io.alu_src_a = 2'b01;
                bus_io.alu_src_b = 2'b10;
                pc_update        = 1'b1;
                state_d          = StAluWb;
            end
            default: state_d = StFetch;
        endcase
    end

    always_comb begin
        case (bus_io.opcode)
            OpSw:    bus_io.imm_src = 2'b01;
            OpBeq:   bus_io.imm_src = 2'b10;
            OpJal:   bus_io.imm_src = 2'b11;
            default: bus_io.imm_src = 2'b00;
        endcase
    end

    assign bus_io.pc_write      = ~reset & (pc_update | (branch & bus_io.zero));
    assign bus_io.ir_write      = ~reset & ir_write_c;
    assign bus_io.mem_write     = ~reset & mem_write_c;
    assign bus_io.reg_write     = ~reset & reg_write_c;
    assign bus_io.illegal_instr = ~reset & illegal_c;
    assign bus_io.state         = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed bench: dut_a uses MEM_WAIT=0/ENABLE_JAL=1, dut_b uses MEM_WAIT=1/ENABLE_JAL=0.
module tb_multicycle_controller;

    logic clk;
    logic reset_a, reset_b;
    int   total, bad;

    multicycle_controller_if if_a ();
    multicycle_controller_if if_b ();

    multicycle_controller #(.MEM_WAIT(0), .ENABLE_JAL(1)) dut_a (
        .clk    (clk),
        .reset  (reset_a),
        .bus_io (if_a)
    );

    multicycle_controller #(.MEM_WAIT(1), .ENABLE_JAL(0)) dut_b (
        .clk    (clk),
        .reset  (reset_b),
        .bus_io (if_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_dut_a();
        reset_a = 1'b1;
        next_cycle();
        reset_a = 1'b0;
    endtask

    task automatic reset_dut_b();
        reset_b = 1'b1;
        next_cycle();
        reset_b = 1'b0;
    endtask

    task automatic test_reset();
        reset_a = 1'b1;
        if_a.opcode = 7'b0000011;
        if_a.mem_ready = 1'b1;
        if_a.zero = 1'b1;
        next_cycle();
        @(negedge clk);
        total++;
        if (if_a.state !== 4'd0) begin
            bad++; $display("FAIL reset_state got=%0d want=0", if_a.state);
        end
        total++;
        if (if_a.ir_write !== 1'b0 || if_a.pc_write !== 1'b0) begin
            bad++; $display("FAIL reset_enables got ir=%b pc=%b want 0 0",
                            if_a.ir_write, if_a.pc_write);
        end
        total++;
        if (if_a.alu_src_b !== 2'b10 || if_a.result_src !== 2'b10) begin
            bad++; $display("FAIL reset_selects got b=%b res=%b want 10 10",
                            if_a.alu_src_b, if_a.result_src);
        end
        next_cycle();
        reset_a = 1'b0;
        @(negedge clk);
        total++;
        if (if_a.ir_write !== 1'b1 || if_a.pc_write !== 1'b1) begin
            bad++; $display("FAIL release_fetch got ir=%b pc=%b want 1 1",
                            if_a.ir_write, if_a.pc_write);
        end
        next_cycle();
    endtask

    task automatic test_lw();
        int exp_st [5] = '{0, 1, 2, 3, 4};
        reset_dut_a();
        if_a.opcode = 7'b0000011;
        if_a.mem_ready = 1'b1;
        if_a.zero = 1'b0;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            total++;
            if (if_a.state !== 4'(exp_st[i])) begin
                bad++; $display("FAIL lw_state[%0d] got=%0d want=%0d", i, if_a.state, exp_st[i]);
            end
            total++;
            if (if_a.reg_write !== 1'(i == 4)) begin
                bad++; $display("FAIL lw_reg_write[%0d] got=%b", i, if_a.reg_write);
            end
            total++;
            if (if_a.ir_write !== 1'(i == 0)) begin
                bad++; $display("FAIL lw_ir_write[%0d] got=%b", i, if_a.ir_write);
            end
            if (i == 4) begin
                total++;
                if (if_a.result_src !== 2'b01) begin
                    bad++; $display("FAIL lw_result_src got=%b want=01", if_a.result_src);
                end
            end
            next_cycle();
        end
        @(negedge clk);
        total++;
        if (if_a.state !== 4'd0) begin
            bad++; $display("FAIL lw_return got=%0d want=0", if_a.state);
        end
    endtask

    task automatic test_rtype_itype();
        logic [6:0] ops [2] = '{7'b0110011, 7'b0010011};
        int         ex [2]  = '{6, 7};
        logic [1:0] srcb [2] = '{2'b00, 2'b01};
        for (int k = 0; k < 2; k++) begin
            reset_dut_a();
            if_a.opcode = ops[k];
            next_cycle();
            next_cycle();
            @(negedge clk);
            total++;
            if (if_a.state !== 4'(ex[k]) || if_a.alu_op !== 2'b10 || if_a.alu_src_b !== srcb[k]) begin
                bad++; $display("FAIL alu_exec[%0d] got st=%0d op=%b b=%b want st=%0d op=10 b=%b",
                                k, if_a.state, if_a.alu_op, if_a.alu_src_b, ex[k], srcb[k]);
            end
            next_cycle();
            @(negedge clk);
            total++;
            if (if_a.state !== 4'd8 || if_a.reg_write !== 1'b1 || if_a.result_src !== 2'b00) begin
                bad++; $display("FAIL alu_wb[%0d] got st=%0d rw=%b res=%b want 8 1 00",
                                k, if_a.state, if_a.reg_write, if_a.result_src);
            end
            next_cycle();
            @(negedge clk);
            total++;
            if (if_a.state !== 4'd0) begin
                bad++; $display("FAIL alu_return[%0d] got=%0d want=0", k, if_a.state);
            end
        end
    endtask

    task automatic test_beq();
        for (int z = 1; z >= 0; z--) begin
            reset_dut_a();
            if_a.opcode = 7'b1100011;
            if_a.zero = 1'(z);
            next_cycle();
            next_cycle();
            @(negedge clk);
            total++;
            if (if_a.state !== 4'd9 || if_a.pc_write !== 1'(z) || if_a.alu_op !== 2'b01) begin
                bad++; $display("FAIL beq_z%0d got st=%0d pcw=%b op=%b want 9 %0d 01",
                                z, if_a.state, if_a.pc_write, if_a.alu_op, z);
            end
            total++;
            if (if_a.imm_src !== 2'b10) begin
                bad++; $display("FAIL beq_imm got=%b want=10", if_a.imm_src);
            end
            next_cycle();
            @(negedge clk);
            total++;
            if (if_a.state !== 4'd0) begin
                bad++; $display("FAIL beq_return_z%0d got=%0d want=0", z, if_a.state);
            end
        end
        if_a.zero = 1'b0;
    endtask

    task automatic test_jal();
        int exp_st [4] = '{0, 1, 10, 8};
        reset_dut_a();
        if_a.opcode = 7'b1101111;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            total++;
            if (if_a.state !== 4'(exp_st[i])) begin
                bad++; $display("FAIL jal_state[%0d] got=%0d want=%0d", i, if_a.state, exp_st[i]);
            end
            if (i == 2) begin
                total++;
                if (if_a.pc_write !== 1'b1 || if_a.imm_src !== 2'b11 || if_a.alu_src_a !== 2'b01) begin
                    bad++; $display("FAIL jal_ctrl got pcw=%b imm=%b a=%b want 1 11 01",
                                    if_a.pc_write, if_a.imm_src, if_a.alu_src_a);
                end
            end
            next_cycle();
        end
        @(negedge clk);
        total++;
        if (if_a.state !== 4'd0) begin
            bad++; $display("FAIL jal_return got=%0d want=0", if_a.state);
        end
        // Same opcode on the jal-disabled instance must be illegal.
        reset_dut_b();
        if_b.opcode = 7'b1101111;
        if_b.mem_ready = 1'b1;
        next_cycle();
        @(negedge clk);
        total++;
        if (if_b.state !== 4'd1 || if_b.illegal_instr !== 1'b1) begin
            bad++; $display("FAIL jal_off_decode got st=%0d ill=%b want 1 1",
                            if_b.state, if_b.illegal_instr);
        end
        next_cycle();
        @(negedge clk);
        total++;
        if (if_b.state !== 4'd0 || if_b.illegal_instr !== 1'b0) begin
            bad++; $display("FAIL jal_off_after got st=%0d ill=%b want 0 0",
                            if_b.state, if_b.illegal_instr);
        end
    endtask

    task automatic test_illegal();
        reset_dut_a();
        if_a.opcode = 7'b1111111;
        next_cycle();
        @(negedge clk);
        total++;
        if (if_a.illegal_instr !== 1'b1 || if_a.reg_write !== 1'b0 || if_a.mem_write !== 1'b0) begin
            bad++; $display("FAIL illegal_pulse got ill=%b rw=%b mw=%b want 1 0 0",
                            if_a.illegal_instr, if_a.reg_write, if_a.mem_write);
        end
        next_cycle();
        @(negedge clk);
        total++;
        if (if_a.state !== 4'd0 || if_a.illegal_instr !== 1'b0) begin
            bad++; $display("FAIL illegal_after got st=%0d ill=%b want 0 0",
                            if_a.state, if_a.illegal_instr);
        end
    endtask

    task automatic test_sw_wait();
        reset_dut_b();
        if_b.opcode = 7'b0100011;
        if_b.mem_ready = 1'b0;
        @(negedge clk);
        total++;
        if (if_b.state !== 4'd0 || if_b.ir_write !== 1'b0) begin
            bad++; $display("FAIL fetch_wait got st=%0d ir=%b want 0 0", if_b.state, if_b.ir_write);
        end
        next_cycle();
        if_b.mem_ready = 1'b1;
        @(negedge clk);
        total++;
        if (if_b.state !== 4'd0 || if_b.ir_write !== 1'b1) begin
            bad++; $display("FAIL fetch_ready got st=%0d ir=%b want 0 1", if_b.state, if_b.ir_write);
        end
        next_cycle();
        next_cycle();
        @(negedge clk);
        total++;
        if (if_b.state !== 4'd2 || if_b.imm_src !== 2'b01) begin
            bad++; $display("FAIL sw_memadr got st=%0d imm=%b want 2 01", if_b.state, if_b.imm_src);
        end
        next_cycle();
        for (int i = 0; i < 3; i++) begin
            if_b.mem_ready = 1'(i == 2);
            @(negedge clk);
            total++;
            if (if_b.state !== 4'd5 || if_b.mem_write !== 1'b1 || if_b.imm_src !== 2'b01) begin
                bad++; $display("FAIL sw_memwrite[%0d] got st=%0d mw=%b imm=%b want 5 1 01",
                                i, if_b.state, if_b.mem_write, if_b.imm_src);
            end
            next_cycle();
        end
        @(negedge clk);
        total++;
        if (if_b.state !== 4'd0 || if_b.mem_write !== 1'b0) begin
            bad++; $display("FAIL sw_return got st=%0d mw=%b want 0 0", if_b.state, if_b.mem_write);
        end
    endtask

    task automatic test_reset_mid();
        reset_dut_b();
        if_b.opcode = 7'b0100011;
        if_b.mem_ready = 1'b1;
        next_cycle();
        next_cycle();
        next_cycle();
        if_b.mem_ready = 1'b0;
        @(negedge clk);
        total++;
        if (if_b.state !== 4'd5 || if_b.mem_write !== 1'b1) begin
            bad++; $display("FAIL mid_pre got st=%0d mw=%b want 5 1", if_b.state, if_b.mem_write);
        end
        reset_b = 1'b1;
        #1;
        total++;
        if (if_b.mem_write !== 1'b0 || if_b.state !== 4'd5) begin
            bad++; $display("FAIL mid_reset_cycle got st=%0d mw=%b want 5 0",
                            if_b.state, if_b.mem_write);
        end
        next_cycle();
        reset_b = 1'b0;
        @(negedge clk);
        total++;
        if (if_b.state !== 4'd0) begin
            bad++; $display("FAIL mid_after got st=%0d want 0", if_b.state);
        end
    endtask

    initial begin
        total = 0;
        bad = 0;
        reset_a = 1'b1;
        reset_b = 1'b1;
        if_a.opcode = 7'b0;
        if_a.zero = 1'b0;
        if_a.mem_ready = 1'b1;
        if_b.opcode = 7'b0;
        if_b.zero = 1'b0;
        if_b.mem_ready = 1'b1;
        test_reset();
        test_lw();
        test_rtype_itype();
        test_beq();
        test_jal();
        test_illegal();
        test_sw_wait();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
